imm_gen_stage: RTL and testbench
================================

# imm_gen_stage

Registered, parametrised immediate-generation stage for the RISC-V decode path. It accepts one 32-bit instruction per cycle over a valid/ready handshake. It classifies the instruction's immediate format, sign- or zero-extends the immediate to XLEN, flags illegal encodings, and presents the result one cycle later with the instruction and a sideband tag. It sits between fetch and register-read and supports stall and pipeline flush.

## Interface
- XLEN, 32: immediate output width; legal values 32 or 64.
- TAG_W, 32: sideband width (PC or ROB tag), passed through unchanged.
- CNT_W, 16: width of the saturating illegal-instruction counter.

Ports (reset is synchronous and active-high):
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  drop the held output; synchronous.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  32  instruction word.
- in_tag  in  TAG_W  sideband.
- out_valid  out  1  output payload valid.
- out_ready  in  1  downstream accepts.
- out_instr  out  32  registered instruction.
- out_tag  out  TAG_W  registered sideband.
- out_imm  out  XLEN  extended immediate.
- out_fmt  out  3  immediate format code.
- out_illegal  out  1  instruction is unrecognised or malformed.
- illegal_cnt  out  CNT_W  saturating count of illegal instructions accepted.

## Operation
- Accept condition: in_valid && in_ready, where in_ready = !flush && (!out_valid || out_ready). in_ready is combinational in out_ready and flush.
- On accept, the payload registers load the decode of in_instr. Otherwise the payload registers hold.
- Decode is keyed on opcode bits [6:2]:
  - 00000 load, 00100 op-imm, 11001 jalr: I-type. imm = sext(instr[31:20]).
  - 00110 op-imm-32: I-type only when XLEN=64; illegal when XLEN=32.
  - 01000 store: S-type. imm = sext({[31:25],[11:7]}).
  - 11000 branch: B-type. imm = sext({[31],[7],[30:25],[11:8],0}).
  - 01101 lui and 00101 auipc: U-type. imm = sext({[31:12],12'b0}).
  - 11011 jal: J-type. imm = sext({[31],[19:12],[20],[30:21],0}).
  - 01100 op, 01110 op-32 (XLEN=64 only), 00011 misc-mem, 11100 system: FMT_NONE, imm = 0.
  - Any other opcode, or instr[1:0] != 2'b11: out_illegal = 1, FMT_NONE, imm = 0.
- Sign extension is always from instr[31] to the full XLEN.
- Shift-immediate forms keep the plain I-type extension; shamt masking belongs to downstream logic.
- illegal_cnt increments by one on each accepted illegal instruction. It saturates at all-ones. It is cleared only by rst; flush does not clear it.

## Timing
- Latency is 1 cycle from accept to out_valid. Throughput is 1 per cycle when out_ready is held high.
- out_valid: set on accept. It clears on out_ready without a new accept, or on flush.
- Stall (out_valid && !out_ready): every out_* signal holds stable and in_ready = 0.
- Flush takes priority over everything else. Next cycle out_valid = 0. No accept happens in the flush cycle. Payload registers keep their stale values.
- Simultaneous out_ready and accept: the new payload replaces the old one with no bubble.
- Reset values: out_valid 0, out_instr 0, out_tag 0, out_imm 0, out_fmt FMT_NONE, out_illegal 0, illegal_cnt 0.
- Reset asserted mid-transfer discards the held instruction. in_ready = 1 on the first cycle after rst deasserts.

## Configuration
- IMMGEN_ZICSR_EN defined: system opcode with funct3 in {101,110,111} gives FMT_Z and imm = zero-extended instr[19:15]. Other system encodings stay FMT_NONE.
- IMMGEN_ZICSR_EN undefined: all system encodings give FMT_NONE and imm 0. FMT_Z is never produced.

## Structure
- Package imm_pkg holds:
  - format codes: FMT_NONE=0, FMT_I=1, FMT_S=2, FMT_B=3, FMT_U=4, FMT_J=5, FMT_Z=6;
  - the opcode[6:2] constants;
  - a struct for {imm, fmt, illegal}.
- Sub-module imm_extract (combinational, parametrised by XLEN) produces that struct from instr.
- imm_gen_stage owns the handshake, the payload registers and the counter.

## Test plan
- I-type: XLEN=32, accept 0xFFF00093 (addi x1,x0,-1) → next cycle out_valid=1, out_fmt=FMT_I, out_imm=0xFFFFFFFF.
- S and B with back-to-back accepts and out_ready=1:
  - 0xFE112E23 (sw x1,-4(x2)) → imm 0xFFFFFFFC, FMT_S;
  - then 0xFE000CE3 (beq x0,x0,-8) → imm 0xFFFFFFF8, FMT_B, no bubble.
- U-type: XLEN=64, 0x800000B7 (lui x1,0x80000) → out_imm=0xFFFFFFFF80000000, FMT_U.
- Stall and flush:
  - hold out_ready=0 for 3 cycles → outputs stable, in_ready=0;
  - assert flush → out_valid=0 next cycle, and the instruction offered during the flush cycle is not accepted.
- Illegal counting: CNT_W=2, accept 0x00000000 five times → out_illegal=1 each time and illegal_cnt steps 1,2,3,3,3; the count survives flush and returns to 0 on rst.
- CSR: with IMMGEN_ZICSR_EN, 0x300FD073 (csrrwi x0,0x300,31) → FMT_Z, imm 0x1F; without the macro → FMT_NONE, imm 0, out_illegal=0.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared types for the immediate-generation stage: format codes, opcode[6:2]
// constants and the decode result struct.
package imm_pkg;

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;

  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_OP_IMM32 = 5'b00110;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_OP32     = 5'b01110;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  // imm is carried at the widest legal XLEN; narrower stages take the low bits,
  // which is still a correct sign extension.
  localparam int IMM_MAXW = 64;

  typedef struct packed {
    logic [IMM_MAXW-1:0] imm;
    logic [2:0]          fmt;
    logic                illegal;
  } imm_res_t;

endpackage

// File: rtl/imm_gen_stage_extract.sv
// Combinational immediate extraction for one instruction word.
// IMMGEN_ZICSR_EN enables the CSR-immediate (FMT_Z) form.
import imm_pkg::*;

module imm_extract #(
  parameter int XLEN = 32
) (
  input  logic [31:0] instr_i,
  output imm_res_t    res_o
);

  logic s;
  assign s = instr_i[31];

  always_comb begin
    res_o = '0;
    res_o.fmt = FMT_NONE;
    unique case (instr_i[6:2])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
        res_o.fmt = FMT_I;
        res_o.imm = {{52{s}}, instr_i[31:20]};
      end
      OPC_OP_IMM32: begin
        if (XLEN == 64) begin
          res_o.fmt = FMT_I;
          res_o.imm = {{52{s}}, instr_i[31:20]};
        end else begin
          res_o.illegal = 1'b1;
        end
      end
      OPC_STORE: begin
        res_o.fmt = FMT_S;
        res_o.imm = {{52{s}}, instr_i[31:25], instr_i[11:7]};
      end
      OPC_BRANCH: begin
        res_o.fmt = FMT_B;
        res_o.imm = {{51{s}}, s, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        res_o.fmt = FMT_U;
        res_o.imm = {{32{s}}, instr_i[31:12], 12'b0};
      end
      OPC_JAL: begin
        res_o.fmt = FMT_J;
        res_o.imm = {{43{s}}, s, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      end
      OPC_OP, OPC_MISC_MEM: ;
      OPC_OP32: res_o.illegal = (XLEN != 64);
      OPC_SYSTEM: begin
`ifdef IMMGEN_ZICSR_EN
        // csrr*i forms carry a 5-bit unsigned immediate in the rs1 field
        if (instr_i[14] && (instr_i[13:12] != 2'b00)) begin
          res_o.fmt = FMT_Z;
          res_o.imm = {{(IMM_MAXW-5){1'b0}}, instr_i[19:15]};
        end
`endif
      end
      default: res_o.illegal = 1'b1;
    endcase

    if (instr_i[1:0] != 2'b11) begin
      res_o.illegal = 1'b1;
      res_o.fmt     = FMT_NONE;
      res_o.imm     = '0;
    end
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage with valid/ready, stall, flush and a
// saturating illegal-instruction counter. Optional macro: IMMGEN_ZICSR_EN.
import imm_pkg::*;

module imm_gen_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [TAG_W-1:0] out_tag,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  imm_res_t res;
  logic     unused_imm_hi;
  logic     accept;

  logic             vld_q,   vld_d;
  logic [31:0]      instr_q, instr_d;
  logic [TAG_W-1:0] tag_q,   tag_d;
  logic [XLEN-1:0]  imm_q,   imm_d;
  logic [2:0]       fmt_q,   fmt_d;
  logic             ill_q,   ill_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr_i (in_instr),
    .res_o   (res)
  );

  assign unused_imm_hi = ^res.imm;

  assign in_ready = !flush && (!vld_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    vld_d   = vld_q;
    instr_d = instr_q;
    tag_d   = tag_q;
    imm_d   = imm_q;
    fmt_d   = fmt_q;
    ill_d   = ill_q;
    cnt_d   = cnt_q;
    // flush wins; accept is already blocked through in_ready
    if (flush)          vld_d = 1'b0;
    else if (accept)    vld_d = 1'b1;
    else if (out_ready) vld_d = 1'b0;
    if (accept) begin
      instr_d = in_instr;
      tag_d   = in_tag;
      imm_d   = res.imm[XLEN-1:0];
      fmt_d   = res.fmt;
      ill_d   = res.illegal;
      if (res.illegal && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= 1'b0;
      instr_q <= '0;
      tag_q   <= '0;
      imm_q   <= '0;
      fmt_q   <= FMT_NONE;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      vld_q   <= vld_d;
      instr_q <= instr_d;
      tag_q   <= tag_d;
      imm_q   <= imm_d;
      fmt_q   <= fmt_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid   = vld_q;
  assign out_instr   = instr_q;
  assign out_tag     = tag_q;
  assign out_imm     = imm_q;
  assign out_fmt     = fmt_q;
  assign out_illegal = ill_q;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: an XLEN=32/CNT_W=2 instance and an XLEN=64 instance.
module tb_imm_gen_stage;

  logic gclk = 1'b0;
  always #5 gclk = ~gclk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge gclk);
    #1;
  endtask

  // XLEN=32, CNT_W=2 instance
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_instr, in_tag, out_instr, out_tag, out_imm;
  logic [2:0]  out_fmt;
  logic [1:0]  illegal_cnt;

  imm_gen_stage #(.XLEN(32), .TAG_W(32), .CNT_W(2)) dut32 (
    .clk(gclk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_tag(out_tag),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
  );

  // XLEN=64 instance
  logic        r64, f64, iv64, ir64, ov64, or64, oil64;
  logic [31:0] ii64, it64, oi64, ot64;
  logic [63:0] oimm64;
  logic [2:0]  ofmt64;
  logic [15:0] cnt64;

  imm_gen_stage #(.XLEN(64), .TAG_W(32), .CNT_W(16)) dut64 (
    .clk(gclk), .rst(r64), .flush(f64),
    .in_valid(iv64), .in_ready(ir64), .in_instr(ii64), .in_tag(it64),
    .out_valid(ov64), .out_ready(or64), .out_instr(oi64), .out_tag(ot64),
    .out_imm(oimm64), .out_fmt(ofmt64), .out_illegal(oil64), .illegal_cnt(cnt64)
  );

  initial begin
    rst = 1; flush = 0; in_valid = 0; in_instr = 0; in_tag = 0; out_ready = 1;
    r64 = 1; f64 = 0; iv64 = 0; ii64 = 0; it64 = 0; or64 = 1;
    step(); step();
    rst = 0; r64 = 0;
    chk("rst_valid", out_valid, 0);
    chk("rst_imm", out_imm, 0);
    chk("rst_fmt", out_fmt, 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_ill", out_illegal, 0);
    chk("rst_cnt", illegal_cnt, 0);
    chk("rst_ready", in_ready, 1);

    // I-type addi x1,x0,-1
    in_valid = 1; in_instr = 32'hFFF00093; in_tag = 32'h100;
    step();
    chk("i_valid", out_valid, 1);
    chk("i_fmt", out_fmt, 1);
    chk("i_imm", out_imm, 64'hFFFFFFFF);
    chk("i_tag", out_tag, 32'h100);

    // back-to-back S then B
    in_instr = 32'hFE112E23; in_tag = 32'h104;
    chk("b2b_ready", in_ready, 1);
    step();
    chk("s_fmt", out_fmt, 2);
    chk("s_imm", out_imm, 64'hFFFFFFFC);
    chk("s_tag", out_tag, 32'h104);
    in_instr = 32'hFE000CE3; in_tag = 32'h108;
    step();
    chk("b_valid", out_valid, 1);
    chk("b_fmt", out_fmt, 3);
    chk("b_imm", out_imm, 64'hFFFFFFF8);
    in_valid = 0;
    step();
    chk("drain_valid", out_valid, 0);

    // stall for 3 cycles then flush
    in_valid = 1; in_instr = 32'hFFF00093; in_tag = 32'h7; out_ready = 0;
    step();
    in_instr = 32'hFE112E23; in_tag = 32'h8;
    for (int i = 0; i < 3; i++) begin
      chk("stall_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
      chk("stall_instr", out_instr, 32'hFFF00093);
      chk("stall_imm", out_imm, 64'hFFFFFFFF);
      chk("stall_tag", out_tag, 32'h7);
      step();
    end
    flush = 1;
    chk("flush_ready", in_ready, 0);
    step();
    flush = 0; in_valid = 0; out_ready = 1;
    chk("flush_valid", out_valid, 0);
    chk("flush_stale_instr", out_instr, 32'hFFF00093);
    chk("flush_stale_tag", out_tag, 32'h7);

    // illegal counting with saturation at 3
    in_valid = 1; in_instr = 32'h0; in_tag = 32'h20;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("ill_flag", out_illegal, 1);
      chk("ill_fmt", out_fmt, 0);
      chk("ill_cnt", illegal_cnt, (i > 3) ? 3 : i);
    end
    flush = 1;
    step();
    flush = 0; in_valid = 0;
    chk("ill_flush_valid", out_valid, 0);
    chk("ill_flush_cnt", illegal_cnt, 3);
    rst = 1;
    step();
    rst = 0;
    chk("ill_rst_cnt", illegal_cnt, 0);
    chk("ill_rst_valid", out_valid, 0);
    chk("ill_rst_ready", in_ready, 1);

    // XLEN=32-only illegal forms, U-type, CSR
    in_valid = 1; in_instr = 32'h0000009B;
    step();
    chk("addiw32_ill", out_illegal, 1);
    in_instr = 32'h00000090;
    step();
    chk("lowbits_ill", out_illegal, 1);
    chk("lowbits_cnt", illegal_cnt, 2);
    in_instr = 32'h12345097;
    step();
    chk("auipc_fmt", out_fmt, 4);
    chk("auipc_imm", out_imm, 64'h12345000);
    chk("auipc_ill", out_illegal, 0);
    in_instr = 32'h300FD073;
    step();
    chk("csr_ill", out_illegal, 0);
`ifdef IMMGEN_ZICSR_EN
    chk("csr_fmt", out_fmt, 6);
    chk("csr_imm", out_imm, 64'h1F);
`else
    chk("csr_fmt", out_fmt, 0);
    chk("csr_imm", out_imm, 0);
`endif
    in_instr = 32'h00000033;
    step();
    chk("op_fmt", out_fmt, 0);
    chk("op_ill", out_illegal, 0);
    chk("op_cnt", illegal_cnt, 2);
    in_valid = 0;

    // XLEN=64 instance
    iv64 = 1; ii64 = 32'h800000B7; it64 = 32'h55;
    step();
    chk("lui64_fmt", ofmt64, 4);
    chk("lui64_imm", oimm64, 64'hFFFFFFFF80000000);
    chk("lui64_tag", ot64, 32'h55);
    ii64 = 32'hFFF0009B;
    step();
    chk("addiw64_fmt", ofmt64, 1);
    chk("addiw64_imm", oimm64, 64'hFFFFFFFFFFFFFFFF);
    chk("addiw64_ill", oil64, 0);
    ii64 = 32'hFF9FF0EF;
    step();
    chk("jal64_fmt", ofmt64, 5);
    chk("jal64_imm", oimm64, 64'hFFFFFFFFFFFFFFF8);
    ii64 = 32'h0000003B;
    step();
    chk("op32_64_ill", oil64, 0);
    chk("op32_64_cnt", cnt64, 0);
    iv64 = 0;
    step();
    chk("v64_drain", ov64, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
